uart_prom_dump: RTL

- UART transmitter that streams the contents of the instruction PROM back out over a serial line.
- Mirror image of the PROM-fill receive path: same framing, same word order (low byte first), same ROM_WORDS wrap.
- Used to verify PROM contents after a load, without a debug port.
- Sits beside the PROM in the top level; reads PROM words through a combinational read port and drives a single TX pin.

---
 rtl/uart_prom_dump.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/uart_prom_dump.sv
// uart_prom_dump: reads ROM_WORDS 16-bit PROM words and sends them out as
// 8N1 UART frames, low byte first, LSB first. Each word is captured whole
// when its low byte starts, so PROM writes during transmission cannot tear it.
module uart_prom_dump #(
  parameter int CLOCK_HZ  = 625,
  parameter int BAUD      = 78,
  parameter int ROM_WORDS = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start_i,
  output logic [$clog2(ROM_WORDS)-1:0] rd_addr_o,
  input  logic [15:0]                  rd_data_i,
  output logic                         tx_o,
  output logic                         busy_o,
  output logic                         done_o
);

  localparam int BIT_CYCLES = CLOCK_HZ / BAUD;
  localparam int CNT_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int ADDR_W     = $clog2(ROM_WORDS);

  localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  BAUD_ONE  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(ROM_WORDS - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        hi_q, hi_d;
  logic              sel_hi_q, sel_hi_d;   // 0: low byte on the wire, 1: high byte
  logic              last_q, last_d;       // high byte of the final word is on the wire
  logic [2:0]        next_bit_s;
  logic              bit_end_s;

  assign next_bit_s = bit_q + 3'd1;
  assign bit_end_s  = (baud_q == BAUD_LAST);

  assign rd_addr_o = addr_q;
  assign tx_o      = tx_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

  // Next-state and next-output computation for the frame sequencer.
  always_comb begin
    state_d  = state_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    addr_d   = addr_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    hi_d     = hi_q;
    sel_hi_d = sel_hi_q;
    last_d   = last_q;
    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (start_i) begin
          shift_d  = rd_data_i[7:0];
          hi_d     = rd_data_i[15:8];
          sel_hi_d = 1'b0;
          last_d   = 1'b0;
          tx_d     = 1'b0;
          busy_d   = 1'b1;
          baud_d   = '0;
          state_d  = S_START;
        end else begin
          baud_d = '0;
        end
      end
      S_START: begin
        if (bit_end_s) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      S_DATA: begin
        if (bit_end_s) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
            // Registered address: step it now so the next word is valid at the end of STOP.
            if (sel_hi_q) begin
              if (addr_q == ADDR_LAST) begin
                last_d = 1'b1;
              end else begin
                addr_d = addr_q + ADDR_ONE;
              end
            end else begin
              last_d = 1'b0;
            end
          end else begin
            bit_d = next_bit_s;
            tx_d  = shift_q[next_bit_s];
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      S_STOP: begin
        if (bit_end_s) begin
          baud_d = '0;
          if (!sel_hi_q) begin
            shift_d  = hi_q;
            sel_hi_d = 1'b1;
            tx_d     = 1'b0;
            state_d  = S_START;
          end else if (!last_q) begin
            shift_d  = rd_data_i[7:0];
            hi_d     = rd_data_i[15:8];
            sel_hi_d = 1'b0;
            tx_d     = 1'b0;
            state_d  = S_START;
          end else begin
            addr_d   = '0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            tx_d     = 1'b1;
            sel_hi_d = 1'b0;
            last_d   = 1'b0;
            state_d  = S_IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      default: begin
        state_d  = S_IDLE;
        tx_d     = 1'b1;
        busy_d   = 1'b0;
        addr_d   = '0;
        baud_d   = '0;
        bit_d    = 3'd0;
        sel_hi_d = 1'b0;
        last_d   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any frame and parks the line high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      addr_q   <= '0;
      baud_q   <= '0;
      bit_q    <= 3'd0;
      shift_q  <= 8'h00;
      hi_q     <= 8'h00;
      sel_hi_q <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      addr_q   <= addr_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      hi_q     <= hi_d;
      sel_hi_q <= sel_hi_d;
      last_q   <= last_d;
    end
  end

endmodule
